data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 7, giving a byte-addressed storage size of 2^ADDR_BITS bytes (128).
REQ-002 SHALL have port CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mRD  input  1  active-low read strobe from the control unit.
REQ-005 SHALL have port mWR  input  1  active-low write strobe from the control unit.
REQ-006 SHALL have port DAddr  input  32  byte address of the word access.
REQ-007 SHALL have port DataIn  input  32  write data.
REQ-008 SHALL have port DataOut  output  32  registered read data.
REQ-009 SHALL have port Ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port Busy  output  1  high while a request is in progress (states XFER, DONE).
REQ-011 SHALL have port Err  output  1  one-cycle error pulse, coincident with Ready.

Function
REQ-012 SHALL implement an FSM with states IDLE, XFER, DONE and ERR, plus a 2-bit byte counter cnt and an armed flag.
REQ-013 SHALL accept a request only in IDLE with armed=1 and exactly one strobe low; at the accept edge it SHALL capture DAddr, DataIn and the direction, clear armed and enter XFER with cnt=0.
REQ-014 SHALL set armed=1 on any edge at which mRD=1 and mWR=1, so a strobe held low across completion never causes a second access.
REQ-015 SHALL treat as an error, at accept: both strobes low, DAddr[1:0]!=0, or DAddr >= 2^ADDR_BITS; it SHALL enter ERR instead of XFER, with no storage write and DataOut unchanged.
REQ-016 SHALL, in XFER, transfer one byte per cycle at address base+cnt, incrementing cnt; after cnt=3 it SHALL enter DONE.
REQ-017 SHALL use big-endian byte order: base+0 carries data[31:24] and base+3 carries data[7:0].
REQ-018 SHALL, on writes, commit each byte to storage at its own XFER edge.
REQ-019 SHALL, on reads, assemble the bytes in a shadow register and load DataOut with the full word at the edge entering DONE; DataOut SHALL never show a partial word.
REQ-020 SHALL drive Ready=1 in DONE and ERR only, and Err=1 in ERR only; both states SHALL last exactly one cycle and return to IDLE.
REQ-021 SHALL have this latency: accept at edge E0; Ready high from E4 to E5 for a valid access, and from E1 to E2 for an error.
REQ-022 SHALL ignore strobe, address and data changes after the accept edge until the FSM returns to IDLE.
REQ-023 SHALL initialise storage to all-zero at simulation start; storage SHALL NOT be cleared by reset.

Reset
REQ-024 SHALL, on RST=1 and regardless of CLK, force state=IDLE, cnt=0, armed=1, DataOut=0, Ready=0, Busy=0 and Err=0.
REQ-025 SHALL, on reset during a write in XFER, keep already-committed bytes and write no further bytes.
REQ-026 SHALL, on reset during a read, discard the partial shadow word.

Verification
REQ-027 SHALL verify write then read: write 0x12345678 to 0x10, then read 0x10 -> Ready 4 cycles after each accept; DataOut=0x12345678; byte 0x10 holds 0x12 and byte 0x13 holds 0x78.
REQ-028 SHALL verify held strobe: mWR held low for 12 cycles at 0x20 with DataIn=0xAABBCCDD -> exactly one Ready pulse; the word is written once; no second Busy period until mWR goes high and then low again.
REQ-029 SHALL verify error cases: a read at 0x13, mRD=mWR=0, and a write at 0x80 -> each gives Ready=Err=1 one cycle after accept; storage and DataOut are unchanged.
REQ-030 SHALL verify reset mid-write: write 0xCAFEF00D to 0x40 and assert RST after 2 XFER cycles -> outputs are 0 immediately; bytes 0x40=0xCA and 0x41=0xFE; bytes 0x42 and 0x43 are unchanged.
REQ-031 SHALL verify input changes mid-read: read 0x10 with DAddr changed to 0x20 during XFER -> DataOut is the word at 0x10.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Byte-addressed data memory that answers one-word requests from a
//             control unit. A word is moved one byte per cycle (big-endian),
//             then a one-cycle Ready pulse reports completion. A bad request
//             (both strobes, misaligned or out-of-range address) is answered
//             with a Ready+Err pulse and has no side effects.
//  Ports    : CLK     - system clock, rising edge
//             RST     - asynchronous active-high reset
//             mRD     - active-low read strobe
//             mWR     - active-low write strobe
//             DAddr   - byte address of the word access
//             DataIn  - write data
//             DataOut - registered read data (only ever a complete word)
//             Ready   - one-cycle completion pulse
//             Busy    - high while a transfer is in progress
//             Err     - one-cycle error pulse, coincident with Ready
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_BITS = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mRD,
    input  logic        mWR,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Busy,
    output logic        Err
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    // Storage starts at zero and is deliberately outside the reset domain.
    logic [7:0] r_mem [0:c_DEPTH-1] = '{default: 8'h00};

    logic [1:0]           r_state;
    logic [1:0]           r_cnt;
    logic                 r_armed;
    logic                 r_is_wr;
    logic [ADDR_BITS-3:0] r_word;    // word index; byte offset comes from r_cnt
    logic [31:0]          r_wdata;
    logic [23:0]          r_shadow;  // first three read bytes; the last joins at DONE

    logic                 w_req;
    logic                 w_bad;
    logic [ADDR_BITS-1:0] w_byte_addr;
    logic [7:0]           w_wbyte;
    logic [7:0]           w_rbyte;

    assign w_req       = ~mRD | ~mWR;
    assign w_bad       = (~mRD & ~mWR) | (|DAddr[1:0]) | (|DAddr[31:ADDR_BITS]);
    assign w_byte_addr = {r_word, r_cnt};
    assign w_rbyte     = r_mem[w_byte_addr];

    // Big-endian: byte offset 0 carries the most significant byte.
    always_comb begin
        w_wbyte = r_wdata[7:0];
        case (r_cnt)
            2'd0:    w_wbyte = r_wdata[31:24];
            2'd1:    w_wbyte = r_wdata[23:16];
            2'd2:    w_wbyte = r_wdata[15:8];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    // Reset drops the FSM out of XFER immediately, so no byte is written
    // after a reset even though this block itself has no reset.
    always_ff @(posedge CLK) begin
        if (r_state == c_XFER && r_is_wr) begin
            r_mem[w_byte_addr] <= w_wbyte;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= c_IDLE;
            r_cnt    <= 2'd0;
            r_armed  <= 1'b1;
            r_is_wr  <= 1'b0;
            r_word   <= '0;
            r_wdata  <= 32'd0;
            r_shadow <= 24'd0;
            DataOut  <= 32'd0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            Ready <= 1'b0;
            Err   <= 1'b0;

            // Re-arm only once both strobes are seen high, so a strobe held
            // low across completion cannot start a second access.
            if (mRD && mWR) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (r_armed && w_req) begin
                        r_armed <= 1'b0;
                        if (w_bad) begin
                            r_state <= c_ERR;
                        end else begin
                            r_state <= c_XFER;
                            r_cnt   <= 2'd0;
                            r_is_wr <= ~mWR;
                            r_word  <= DAddr[ADDR_BITS-1:2];
                            r_wdata <= DataIn;
                            Busy    <= 1'b1;
                        end
                    end
                end
                c_XFER: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (!r_is_wr) begin
                        case (r_cnt)
                            2'd0:    r_shadow[23:16] <= w_rbyte;
                            2'd1:    r_shadow[15:8]  <= w_rbyte;
                            2'd2:    r_shadow[7:0]   <= w_rbyte;
                            default: DataOut         <= {r_shadow, w_rbyte};
                        endcase
                    end
                    if (r_cnt == 2'd3) begin
                        r_state <= c_DONE;
                        Ready   <= 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    // Error pulse is registered on leaving ERR: it appears
                    // one cycle after the accept edge.
                    r_state <= c_IDLE;
                    Ready   <= 1'b1;
                    Err     <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder: a table of word
//             accesses with hand-computed results, plus directed sequences for
//             held strobes, reset during a write and inputs changing mid-read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        CLK;
    logic        RST;
    logic        mRD;
    logic        mWR;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Ready;
    logic        Busy;
    logic        Err;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_responder #(.ADDR_BITS(7)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .mRD     (mRD),
        .mWR     (mWR),
        .DAddr   (DAddr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .Ready   (Ready),
        .Busy    (Busy),
        .Err     (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic        err;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Strobes high for one full edge so the responder is idle and re-armed.
    task automatic gap();
        @(negedge CLK);
        mRD = 1'b1;
        mWR = 1'b1;
        @(negedge CLK);
    endtask

    // Returns number of edges after the accept edge until Ready (0 = timeout).
    task automatic wait_ready(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            if (Ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] din,
                          input logic err, input logic [31:0] dout);
        int lat;
        gap();
        mRD    = ~rd;
        mWR    = ~wr;
        DAddr  = addr;
        DataIn = din;
        @(posedge CLK);
        #1;
        mRD    = 1'b1;
        mWR    = 1'b1;
        DAddr  = $urandom;
        DataIn = $urandom;
        chk({nm, " busy"}, {31'd0, Busy}, {31'd0, ~err});
        wait_ready(lat);
        chk({nm, " latency"}, lat, err ? 32'd1 : 32'd4);
        chk({nm, " err"}, {31'd0, Err}, {31'd0, err});
        chk({nm, " dataout"}, DataOut, dout);
    endtask

    initial begin
        int lat;
        int n_ready;
        int n_busy_rise;
        logic prev_busy;

        //          rd    wr    addr          din             err   dout
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_007C, 32'h0102_0304, 1'b0, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_007C, 32'h0000_0000, 1'b0, 32'h0102_0304};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0102_0304};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0102_0304};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 1'b1, 32'h0102_0304};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678};

        RST    = 1'b1;
        mRD    = 1'b1;
        mWR    = 1'b1;
        DAddr  = 32'd0;
        DataIn = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset dataout", DataOut, 32'd0);
        chk("reset ready", {31'd0, Ready}, 32'd0);
        chk("reset busy", {31'd0, Busy}, 32'd0);
        chk("reset err", {31'd0, Err}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 9; i++) begin
            access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                   vecs[i].din, vecs[i].err, vecs[i].dout);
        end
        chk("byte 0x10", {24'd0, dut.r_mem[16]}, 32'h12);
        chk("byte 0x13", {24'd0, dut.r_mem[19]}, 32'h78);

        // Held write strobe: one access only, later data changes ignored.
        gap();
        mWR    = 1'b0;
        DAddr  = 32'h20;
        DataIn = 32'hAABB_CCDD;
        n_ready     = 0;
        n_busy_rise = 0;
        prev_busy   = Busy;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (i == 1) DataIn = 32'h5555_5555;
            if (Ready) n_ready++;
            if (Busy && !prev_busy) n_busy_rise++;
            prev_busy = Busy;
        end
        chk("held ready pulses", n_ready, 32'd1);
        chk("held busy periods", n_busy_rise, 32'd1);
        access("held readback", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hAABB_CCDD);

        // Reset after two write bytes have been committed.
        gap();
        mWR    = 1'b0;
        DAddr  = 32'h40;
        DataIn = 32'hCAFE_F00D;
        @(posedge CLK);
        #1;
        mWR = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst dataout", DataOut, 32'd0);
        chk("rst busy", {31'd0, Busy}, 32'd0);
        chk("rst ready", {31'd0, Ready}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        chk("byte 0x40", {24'd0, dut.r_mem[64]}, 32'hCA);
        chk("byte 0x41", {24'd0, dut.r_mem[65]}, 32'hFE);
        chk("byte 0x42", {24'd0, dut.r_mem[66]}, 32'h00);
        chk("byte 0x43", {24'd0, dut.r_mem[67]}, 32'h00);
        access("rst readback", 1'b1, 1'b0, 32'h40, 32'd0, 1'b0, 32'hCAFE_0000);

        // Address changes during a read transfer are ignored.
        gap();
        mRD   = 1'b0;
        DAddr = 32'h10;
        @(posedge CLK);
        #1;
        DAddr = 32'h20;
        wait_ready(lat);
        chk("midread latency", lat, 32'd4);
        chk("midread dataout", DataOut, 32'h1234_5678);
        mRD = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
